// File: rtl/regfile_pkg.sv
// Shared constants and reset-pattern helper for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;

   localparam int RP_ZERO = 0;
   localparam int RP_TEST = 1;

   // Test pattern: R[i] = 10*i+1 below the top two registers, which hold 10.
   function automatic logic [31:0] reset_value(input int idx, input int nregs, input int pattern);
      logic [31:0] v;
      v = '0;
      if (pattern == RP_TEST && idx != 0) begin
         if (idx <= nregs - 3) v = 32'(10 * idx + 1);
         else                  v = 32'd10;
      end
      return v;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy bits: an issue mark sets, a writeback clears, set wins on collision.
module regfile_scoreboard_busy
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iss_valid,
   input  logic [ADDR_W-1:0]   iss_addr,
   input  logic                we,
   input  logic [ADDR_W-1:0]   wr_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                busy_any
);

   logic [NUM_REGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (iss_valid && iss_addr == ADDR_W'(r))
            busy_d[r] = 1'b1;
         else if (we && wr_addr == ADDR_W'(r))
            busy_d[r] = 1'b0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_vec = busy_q;
   assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass, hard-wired zero R0 and a busy scoreboard.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int NUM_REGS      = DEF_NUM_REGS,
   parameter int ADDR_W        = $clog2(NUM_REGS),
   parameter int NUM_RD        = 2,
   parameter int RESET_PATTERN = RP_ZERO
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     busy_any,
   output logic [NUM_REGS-1:0]      busy_vec
);

   logic [NUM_REGS-1:0][DATA_W-1:0] view;

   assign view[0] = '0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      logic [DATA_W-1:0] val_q, val_d;

      always_comb begin
         val_d = val_q;
         if (we && wr_addr == ADDR_W'(r)) val_d = wr_data;
      end

      always_ff @(posedge clk) begin
         if (reset) val_q <= DATA_W'(reset_value(r, NUM_REGS, RESET_PATTERN));
         else       val_q <= val_d;
      end

      assign view[r] = val_q;
   end

   regfile_scoreboard_busy #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_busy (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .we        (we),
      .wr_addr   (wr_addr),
      .busy_vec  (busy_vec),
      .busy_any  (busy_any)
   );

   // A same-cycle writeback both forwards its data and satisfies the pending dependency.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;

      assign addr = rd_addr[k*ADDR_W +: ADDR_W];
      assign hit  = we && (wr_addr == addr);

      assign rd_data[k*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                           hit          ? wr_data : view[addr];
      assign rd_ready[k] = (addr == '0) || !busy_vec[addr] || hit;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file with the test reset pattern loaded.
module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int RD = 2;

   logic             clk;
   logic             reset;
   logic [RD*AW-1:0] rd_addr;
   logic [RD*DW-1:0] rd_data;
   logic [RD-1:0]    rd_ready;
   logic             we;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             iss_valid;
   logic [AW-1:0]    iss_addr;
   logic             busy_any;
   logic [NR-1:0]    busy_vec;

   int total = 0;
   int bad   = 0;

   regfile_scoreboard #(
      .DATA_W        (DW),
      .NUM_REGS      (NR),
      .ADDR_W        (AW),
      .NUM_RD        (RD),
      .RESET_PATTERN (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .busy_any  (busy_any),
      .busy_vec  (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
      #2;
   endtask

   task automatic idle();
      we = 1'b0; iss_valid = 1'b0; wr_addr = '0; wr_data = '0; iss_addr = '0;
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0;
      idle();
      tick(); tick();
      reset = 1'b0;

      // reset pattern
      rd(5'd1, 5'd5);
      chk("rst_r1", rd_data[31:0], 64'd11);
      chk("rst_r5", rd_data[63:32], 64'd51);
      rd(5'd30, 5'd31);
      chk("rst_r30", rd_data[31:0], 64'd10);
      chk("rst_r31", rd_data[63:32], 64'd10);
      rd(5'd0, 5'd2);
      chk("rst_r0", rd_data[31:0], 64'd0);
      chk("rst_r2", rd_data[63:32], 64'd21);
      chk("rst_busy", busy_vec, 64'd0);
      chk("rst_any", busy_any, 64'd0);
      chk("rst_ready", rd_ready, 64'd3);

      // bypass in write cycle, storage afterwards; write while not busy
      we = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
      rd(5'd7, 5'd8);
      chk("byp_r7", rd_data[31:0], 64'hDEADBEEF);
      chk("byp_r8", rd_data[63:32], 64'd81);
      tick(); idle();
      rd(5'd7, 5'd7);
      chk("st_r7_p0", rd_data[31:0], 64'hDEADBEEF);
      chk("st_r7_p1", rd_data[63:32], 64'hDEADBEEF);
      chk("st_busy", busy_vec, 64'd0);

      // R0 ignores writes and issues
      we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_valid = 1'b1; iss_addr = 5'd0;
      rd(5'd0, 5'd0);
      chk("r0_wcyc", rd_data, 64'd0);
      tick(); idle();
      rd(5'd0, 5'd0);
      chk("r0_after", rd_data, 64'd0);
      chk("r0_busy", busy_vec, 64'd0);

      // issue R9, stall, writeback releases
      iss_valid = 1'b1; iss_addr = 5'd9;
      rd(5'd9, 5'd1);
      chk("iss_samecyc_rdy", rd_ready, 64'd3);
      tick(); idle();
      rd(5'd9, 5'd1);
      chk("r9_busy_rdy", rd_ready, 64'd2);
      chk("r9_busy_vec", busy_vec, 64'h200);
      chk("r9_busy_any", busy_any, 64'd1);
      tick();
      rd(5'd9, 5'd9);
      chk("r9_still_busy", rd_ready, 64'd0);
      we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      rd(5'd9, 5'd9);
      chk("r9_wb_rdy", rd_ready, 64'd3);
      chk("r9_wb_data", rd_data, {32'h55, 32'h55});
      tick(); idle();
      rd(5'd9, 5'd9);
      chk("r9_clr_vec", busy_vec, 64'd0);
      chk("r9_clr_any", busy_any, 64'd0);
      chk("r9_clr_data", rd_data[31:0], 64'h55);

      // issue and writeback to the same register: busy wins, data lands
      iss_valid = 1'b1; iss_addr = 5'd4; we = 1'b1; wr_addr = 5'd4; wr_data = 32'hABCD;
      tick(); idle();
      rd(5'd4, 5'd0);
      chk("col_busy", busy_vec, 64'h10);
      chk("col_data", rd_data[31:0], 64'hABCD);
      chk("col_rdy", rd_ready, 64'd2);

      // reset discards pending busy state and dominates a write
      iss_valid = 1'b1; iss_addr = 5'd3; tick();
      iss_addr = 5'd12; tick(); idle();
      we = 1'b1; wr_addr = 5'd20; wr_data = 32'hFF; tick(); idle();
      rd(5'd20, 5'd3);
      chk("pre_busy", busy_vec, 64'h1018);
      chk("pre_r20", rd_data[31:0], 64'hFF);
      reset = 1'b1; we = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
      iss_valid = 1'b1; iss_addr = 5'd5;
      tick();
      reset = 1'b0; idle();
      rd(5'd20, 5'd7);
      chk("mid_busy", busy_vec, 64'd0);
      chk("mid_any", busy_any, 64'd0);
      chk("mid_r20", rd_data[31:0], 64'd201);
      chk("mid_r7", rd_data[63:32], 64'd71);
      chk("mid_rdy", rd_ready, 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor register file for the MIPS datapath: NUM_REGS × DATA_W storage, NUM_RD combinational read ports with same-cycle write-to-read bypass, and one clocked write port. Register 0 is hard-wired to zero. A per-register busy scoreboard marks registers with an outstanding producer, so the pipelined core can stall dependent reads. Sits between decode (reads and issue marks) and writeback (writes and busy clears).

## Interface
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS): register index width.
- NUM_RD, 2: number of read ports, 1 to 4.
- RESET_PATTERN, 0: reset contents.
  - 0: all registers are zero.
  - 1: test pattern. R[i] = 10*i+1 for 1 ≤ i ≤ NUM_REGS-3; the top two registers are 10; R0 is 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_ready  out  NUM_RD  port k's operand is valid this cycle (not pending).
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- iss_valid  in  1  issue mark: register iss_addr gets an outstanding producer.
- iss_addr  in  ADDR_W  destination index being marked busy.
- busy_any  out  1  OR of all busy bits.
- busy_vec  out  NUM_REGS  raw busy bits; bit 0 is always 0.

## Operation
- **Storage:** one DATA_W register per index 1..NUM_REGS-1. Index 0 has no storage and always reads 0.
- **Write:** if we=1 and wr_addr≠0, R[wr_addr] takes wr_data at the edge. A write to index 0 is ignored.
- **Read port k (combinational):**
  - rd_addr=0 → 0.
  - else if we=1 and wr_addr=rd_addr → wr_data (bypass).
  - else → R[rd_addr].
- **Scoreboard, at each edge for register r≠0:**
  - set = iss_valid & (iss_addr=r)
  - clr = we & (wr_addr=r)
  - busy[r] ← set ? 1 : (clr ? 0 : busy[r])
  - When set and clr hit the same register in one cycle, set wins: the new producer supersedes the one writing back.
- **rd_ready[k]:** 1 if rd_addr=0, or busy[rd_addr]=0, or (we=1 and wr_addr=rd_addr). The third term means the bypass satisfies the dependency in the writeback cycle.
- **Write while not busy:** allowed. It updates R and leaves busy at 0; writes are not required to be paired with issues.
- **Issue to index 0:** ignored.
- **Multiple read ports:** may address the same index; each resolves independently.
- **Reset:**
  - Sets every R to the RESET_PATTERN value and clears every busy bit.
  - Dominates we and iss_valid in the same cycle.
  - Asserting reset mid-operation discards all pending busy state.
- **Out-of-range indices:** cannot occur (NUM_REGS is a power of two).

## Timing
- Read latency 0: rd_data and rd_ready are combinational from rd_addr, we, wr_addr, wr_data and state.
- Write latency 1: the value is visible from storage in the cycle after the edge, and visible via bypass in the write cycle itself.
- Scoreboard latency 1:
  - After an issue at edge N, busy is visible from cycle N+1.
  - A reader in the same cycle as the issue sees the old busy state.
- Reset values, first cycle after the reset edge:
  - busy_vec=0, busy_any=0, rd_ready=all 1s.
  - rd_data = pattern value at the addressed index.
- No combinational path from iss_valid or iss_addr to any output.

## Structure
- Shared package `regfile_pkg`:
  - default DATA_W and NUM_REGS constants;
  - the RESET_PATTERN encodings RP_ZERO=0 and RP_TEST=1;
  - a function reset_value(idx) returning the pattern word.
- One sub-module, `regfile_scoreboard_busy`: the NUM_REGS busy-bit array with set/clear priority and busy_any.
- Storage and read muxing stay in the top level.

## Test plan
1. RESET_PATTERN=1, pulse reset, then read R1, R5, R30, R31, R0 → 11, 51, 10, 10, 0. busy_vec=0.
2. we=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr0=7 in the same cycle → rd_data0=0xDEADBEEF (bypass). Next cycle with we=0 → still 0xDEADBEEF.
3. Write 0x1234 to R0, then read R0 on both ports → 0. busy_vec[0] stays 0 after iss_valid with iss_addr=0.
4. Issue R9 at cycle N → rd_ready=0 for R9 in cycles N+1..M-1. Write R9=0x55 at cycle M → rd_ready=1 and rd_data=0x55 in cycle M. busy[9]=0 from M+1.
5. Same cycle: iss_valid with iss_addr=4, and we with wr_addr=4 → busy[4]=1 afterwards, and R4 holds the written data.
6. Issue R3 and R12, write R20=0xFF, then assert reset for one cycle with we=1 → busy_vec=0, busy_any=0, R20 = reset value (0 for RESET_PATTERN=0), and the write is dropped.
